// File: rtl/kernel_sysid_pkg.sv
// Shared types and constants for the kernel system-ID checker.
// Word map of the sysid slave and the FSM state encoding.
package kernel_sysid_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdId,
        StLatId,
        StRdTs,
        StLatTs,
        StFinish
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int unsigned TIMEOUT_CNT_W = 16;

    typedef logic [TIMEOUT_CNT_W-1:0] tmo_cnt_t;

    function automatic logic is_read_state(sysid_state_e s);
        return (s == StRdId) || (s == StRdTs);
    endfunction

    function automatic logic is_ts_state(sysid_state_e s);
        return (s == StRdTs) || (s == StLatTs);
    endfunction

endpackage

// File: rtl/kernel_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// compares them against the build-time expected values.
module kernel_sysid_checker
    import kernel_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1483507502,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam tmo_cnt_t TmoLimit = tmo_cnt_t'(TIMEOUT_CYCLES);
    // Only meaningful when READ_LATENCY > 0; the latency states are unreachable otherwise.
    localparam tmo_cnt_t LatLast =
        tmo_cnt_t'((READ_LATENCY > 0) ? READ_LATENCY - 1 : READ_LATENCY);

    sysid_state_e state_q, state_d;
    tmo_cnt_t     cnt_q, cnt_d;
    tmo_cnt_t     cnt_inc;
    logic         read_q, read_d;
    logic         address_q, address_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         pass_q, pass_d;
    logic         timeout_q, timeout_d;
    logic [31:0]  id_q, id_d;
    logic [31:0]  ts_q, ts_d;

    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        id_d      = id_q;
        ts_d      = ts_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    id_d      = '0;
                    ts_d      = '0;
                    cnt_d     = '0;
                    state_d   = StRdId;
                end
            end
            StRdId, StRdTs: begin
                if (waitrequest) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TmoLimit) begin
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                        state_d   = StFinish;
                    end
                end else begin
                    cnt_d = '0;
                    if (READ_LATENCY == 0) begin
                        if (state_q == StRdId) begin
                            id_d    = readdata;
                            state_d = StRdTs;
                        end else begin
                            ts_d    = readdata;
                            state_d = StFinish;
                        end
                    end else begin
                        state_d = (state_q == StRdId) ? StLatId : StLatTs;
                    end
                end
            end
            StLatId, StLatTs: begin
                if (cnt_q == LatLast) begin
                    cnt_d = '0;
                    if (state_q == StLatId) begin
                        id_d    = readdata;
                        state_d = StRdTs;
                    end else begin
                        ts_d    = readdata;
                        state_d = StFinish;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Verdict uses the freshly captured words so it is valid alongside done.
        if (state_d == StFinish && !timeout_d) begin
            pass_d = (id_d == EXPECTED_ID) && (ts_d == EXPECTED_TS);
        end

        read_d    = is_read_state(state_d);
        address_d = is_ts_state(state_d) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StFinish);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            read_q    <= 1'b0;
            address_q <= SYSID_ADDR_ID;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            id_q      <= '0;
            ts_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            read_q    <= read_d;
            address_q <= address_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            id_q      <= id_d;
            ts_q      <= ts_d;
        end
    end

    assign read     = read_q;
    assign address  = address_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign timeout  = timeout_q;
    assign id_value = id_q;
    assign ts_value = ts_q;

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Bench for kernel_sysid_checker: three parameterisations share one sysid slave model,
// randomized stall/latency/content runs are scored against a cycle-count reference model.
module tb_kernel_sysid_checker;

    localparam logic [31:0] TsStock = 32'd1483507502;
    localparam logic [31:0] Garbage = 32'hA5A5_5A5A;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic [2:0]  start;
    logic [2:0]  read;
    logic [2:0]  address;
    logic [2:0]  waitreq;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  pass;
    logic [2:0]  timeout;
    logic [31:0] id_v [3];
    logic [31:0] ts_v [3];
    logic [31:0] rdata_s;

    logic [1:0]  sel;
    int          stall_tgt [2];
    logic [31:0] sl_id;
    logic [31:0] sl_ts;

    int          stall_cnt;
    logic        acc_pend;
    int          acc_age;
    logic [31:0] acc_data;
    int          acc_total = 0;
    logic [15:0] acc_hist = '0;
    int          viol = 0;
    logic        prev_read, prev_wr, prev_addr;
    logic        rd_s, ad_s, wr_s;
    int          lat_s;

    int n_vec = 0;
    int n_miss = 0;

    kernel_sysid_checker u_dut0 (
        .clock(clock), .reset_n(reset_n), .start(start[0]), .address(address[0]),
        .read(read[0]), .waitrequest(waitreq[0]), .readdata(rdata_s), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .timeout(timeout[0]), .id_value(id_v[0]),
        .ts_value(ts_v[0])
    );

    kernel_sysid_checker #(
        .EXPECTED_TS(32'd1483507503)
    ) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start[1]), .address(address[1]),
        .read(read[1]), .waitrequest(waitreq[1]), .readdata(rdata_s), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .timeout(timeout[1]), .id_value(id_v[1]),
        .ts_value(ts_v[1])
    );

    kernel_sysid_checker #(
        .READ_LATENCY(2),
        .TIMEOUT_CYCLES(4)
    ) u_dut2 (
        .clock(clock), .reset_n(reset_n), .start(start[2]), .address(address[2]),
        .read(read[2]), .waitrequest(waitreq[2]), .readdata(rdata_s), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .timeout(timeout[2]), .id_value(id_v[2]),
        .ts_value(ts_v[2])
    );

    // Sysid slave model, attached to whichever DUT is selected.
    assign rd_s    = read[sel];
    assign ad_s    = address[sel];
    assign lat_s   = (sel == 2'd2) ? 2 : 0;
    assign wr_s    = rd_s && (stall_cnt < stall_tgt[ad_s]);
    assign waitreq = wr_s ? (3'b001 << sel) : 3'b000;
    assign rdata_s = (lat_s == 0) ? ((rd_s && !wr_s) ? (ad_s ? sl_ts : sl_id) : Garbage)
                                  : ((acc_pend && acc_age == lat_s) ? acc_data : Garbage);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 0;
            acc_pend  <= 1'b0;
            acc_age   <= 0;
            acc_data  <= '0;
            prev_read <= 1'b0;
            prev_wr   <= 1'b0;
            prev_addr <= 1'b0;
        end else begin
            stall_cnt <= (rd_s && wr_s) ? stall_cnt + 1 : 0;
            if (rd_s && !wr_s) begin
                acc_pend  <= 1'b1;
                acc_age   <= 1;
                acc_data  <= ad_s ? sl_ts : sl_id;
                acc_total <= acc_total + 1;
                acc_hist  <= {acc_hist[14:0], ad_s};
            end else if (acc_pend) begin
                acc_age <= acc_age + 1;
            end
            if (prev_read && prev_wr && rd_s && (ad_s != prev_addr)) viol <= viol + 1;
            prev_read <= rd_s;
            prev_wr   <= wr_s;
            prev_addr <= ad_s;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: each accepted read costs stall+1+latency cycles, a timed-out read costs
    // the timeout limit, and the check starts one cycle after start is sampled.
    task automatic model(input logic [1:0] g, input int s0, input int s1,
                         input logic [31:0] sid, input logic [31:0] sts,
                         output int cyc, output int e_acc, output logic e_pass,
                         output logic e_to, output logic [31:0] e_id, output logic [31:0] e_ts);
        int          lat;
        int          tmo;
        logic [31:0] exp_ts;
        lat    = (g == 2'd2) ? 2 : 0;
        tmo    = (g == 2'd2) ? 4 : 255;
        exp_ts = (g == 2'd1) ? 32'd1483507503 : TsStock;
        e_id = '0; e_ts = '0; e_to = 1'b0; e_pass = 1'b0; e_acc = 0; cyc = 1;
        if (s0 >= tmo) begin
            e_to = 1'b1;
            cyc += tmo;
        end else begin
            e_id  = sid;
            e_acc = 1;
            cyc  += s0 + 1 + lat;
            if (s1 >= tmo) begin
                e_to = 1'b1;
                cyc += tmo;
            end else begin
                e_ts   = sts;
                e_acc  = 2;
                cyc   += s1 + 1 + lat;
                e_pass = (sid == 32'd0) && (sts == exp_ts);
            end
        end
    endtask

    task automatic run_check(input logic [1:0] g, input int s0, input int s1,
                             input logic [31:0] sid, input logic [31:0] sts, input bit extra);
        int          e_cyc, e_acc, n, tot0, viol0, extra_at, late_done;
        logic        e_pass, e_to;
        logic [31:0] e_id, e_ts;
        model(g, s0, s1, sid, sts, e_cyc, e_acc, e_pass, e_to, e_id, e_ts);
        @(negedge clock);
        sel          = g;
        stall_tgt[0] = s0;
        stall_tgt[1] = s1;
        sl_id        = sid;
        sl_ts        = sts;
        tot0         = acc_total;
        viol0        = viol;
        extra_at     = extra ? int'($urandom_range(e_cyc, 1)) : 0;
        start[g]     = 1'b1;
        @(posedge clock);
        #1;
        start[g] = 1'b0;
        n = 1;
        check_eq("busy_rise", 32'(busy[g]), 32'd1);
        while (1) begin
            if (n == extra_at) start[g] = 1'b1;
            if (done[g] || n >= 300) break;
            @(posedge clock);
            #1;
            start[g] = 1'b0;
            n++;
        end
        check_eq("done_cycle", n, e_cyc);
        check_eq("pass", 32'(pass[g]), 32'(e_pass));
        check_eq("timeout", 32'(timeout[g]), 32'(e_to));
        check_eq("id_value", id_v[g], e_id);
        check_eq("ts_value", ts_v[g], e_ts);
        check_eq("accepts", acc_total - tot0, e_acc);
        if (e_acc == 2) check_eq("addr_order", {30'd0, acc_hist[1:0]}, 32'd1);
        check_eq("stall_stable", viol - viol0, 0);
        @(posedge clock);
        #1;
        start[g] = 1'b0;
        check_eq("busy_fall", 32'(busy[g]), 32'd0);
        late_done = 0;
        repeat (24) begin
            @(posedge clock);
            #1;
            if (done[g]) late_done++;
        end
        check_eq("single_done", late_done, 0);
        check_eq("pass_hold", 32'(pass[g]), 32'(e_pass));
    endtask

    task automatic check_all_clear(input string tag);
        check_eq({tag, "_read"}, {29'd0, read}, 32'd0);
        check_eq({tag, "_busy"}, {29'd0, busy}, 32'd0);
        check_eq({tag, "_done"}, {29'd0, done}, 32'd0);
        check_eq({tag, "_pass"}, {29'd0, pass}, 32'd0);
        check_eq({tag, "_timeout"}, {29'd0, timeout}, 32'd0);
        check_eq({tag, "_address"}, {29'd0, address}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq({tag, "_id"}, id_v[i], 32'd0);
            check_eq({tag, "_ts"}, ts_v[i], 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  g;
        int          s0, s1;
        logic [31:0] sid, sts;
        reset_n      = 1'b0;
        start        = '0;
        sel          = 2'd0;
        stall_tgt[0] = 0;
        stall_tgt[1] = 0;
        sl_id        = '0;
        sl_ts        = TsStock;
        repeat (3) @(posedge clock);
        #1;
        check_all_clear("reset");
        @(negedge clock);
        reset_n = 1'b1;

        run_check(2'd0, 0, 0, 32'd0, TsStock, 1'b0);
        run_check(2'd1, 0, 0, 32'd0, TsStock, 1'b0);
        run_check(2'd0, 3, 3, 32'd0, TsStock, 1'b0);
        run_check(2'd2, 1000, 0, 32'd0, TsStock, 1'b0);
        run_check(2'd2, 0, 0, 32'd0, TsStock, 1'b1);

        // Reset while the timestamp read is stalled.
        @(negedge clock);
        sel          = 2'd0;
        stall_tgt[0] = 0;
        stall_tgt[1] = 40;
        sl_id        = 32'h1234_5678;
        sl_ts        = TsStock;
        start[0]     = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
            start[0] = 1'b0;
        end
        check_eq("pre_rst_read", 32'(read[0]), 32'd1);
        check_eq("pre_rst_addr", 32'(address[0]), 32'd1);
        check_eq("pre_rst_id", id_v[0], 32'h1234_5678);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_clear("midrst");
        @(negedge clock);
        reset_n = 1'b1;
        run_check(2'd0, 0, 0, 32'd0, TsStock, 1'b0);

        for (int i = 0; i < 40; i++) begin
            g   = 2'($urandom_range(2, 0));
            s0  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(6, 0)) : 0;
            s1  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(6, 0)) : 0;
            sid = ($urandom_range(3, 0) == 0) ? $urandom : 32'd0;
            sts = ($urandom_range(3, 0) == 0) ? $urandom : TsStock;
            if ($urandom_range(4, 0) == 0) sts = 32'd1483507503;
            run_check(g, s0, s1, sid, sts, 1'($urandom_range(1, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/kernel_sysid_checker.md
# kernel_sysid_checker

Avalon-MM read master that queries the system-ID slave in the kernel Qsys system and confirms that the loaded FPGA image matches the build the software expects. On a start pulse it reads word 0 (ID) and word 1 (timestamp), captures both, compares them against parameters, and reports pass/fail/timeout. It sits beside the Nios II on the same clock and reset and gates firmware boot or drives a status LED.

## Interface

Parameters:
- EXPECTED_ID, 32'd0, expected value at word address 0
- EXPECTED_TS, 32'd1483507502, expected value at word address 1
- READ_LATENCY, 0, fixed slave read latency in cycles (0..3)
- TIMEOUT_CYCLES, 255, maximum cycles spent in waitrequest per read (1..65535)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run one check; ignored while busy
- address  out  1  Avalon word address to the sysid slave
- read  out  1  Avalon read strobe
- waitrequest  in  1  slave stall; tie 0 for the stock sysid slave
- readdata  in  32  slave read data
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check finishes, whether pass, fail or timeout
- pass  out  1  sticky: last check matched both words
- timeout  out  1  sticky: last check aborted on waitrequest timeout
- id_value  out  32  captured word 0
- ts_value  out  32  captured word 1

## Operation

- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FINISH.
- IDLE: read=0, address=0. When start=1, clear pass, timeout, id_value and ts_value, then go to RD_ID.
- RD_ID: read=1, address=0, held stable while waitrequest=1. When waitrequest=0, the read is accepted. With READ_LATENCY=0, capture readdata into id_value in the same cycle and go to RD_TS. Otherwise go to LAT_ID.
- LAT_ID: read=0. Count READ_LATENCY cycles, capture readdata on the last one, then go to RD_TS.
- RD_TS and LAT_TS: same as RD_ID and LAT_ID, with address=1 and capture into ts_value. They exit to FINISH.
- FINISH: lasts one cycle. done=1. pass = (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TS). Return to IDLE.
- Timeout counter: 16-bit. Cleared on entry to each RD_* state and incremented on each cycle with read=1 && waitrequest=1. When it reaches TIMEOUT_CYCLES with waitrequest still 1:
  - drop read;
  - set timeout=1 and pass=0;
  - go to FINISH; words not yet read keep their cleared value of 0.
- Comparison is a full 32-bit equality; no masking.
- start while busy=1 has no effect and is not queued.
- start arriving in the same cycle as FINISH is ignored, because busy is still 1.

## Timing

- Reset values: read=0, address=0, busy=0, done=0, pass=0, timeout=0, id_value=0, ts_value=0, state=IDLE, counters=0.
- All outputs are registered.
- busy rises the cycle after start is sampled and falls in the cycle after FINISH.
- With waitrequest=0 and READ_LATENCY=0: start at cycle 0, read at cycles 1 and 2, done and pass valid at cycle 3.
- Each waitrequest cycle adds one cycle. READ_LATENCY=L adds L cycles per word.
- read is never asserted in two consecutive accepted cycles to different addresses without the state transition between them. address changes only while read=0, or in the cycle after acceptance.
- Reset mid-operation returns everything to reset values immediately. No partial done pulse is emitted.
- pass and timeout hold until the next accepted start.

## Structure

- Shared package kernel_sysid_pkg holds:
  - the state enum;
  - word-address constants SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1;
  - the timeout counter width constant.
- No sub-module. The latency/timeout counter and the FSM live in one module. The bench instantiates the existing sysid slave as the DUT target.

## Test plan

- Defaults, waitrequest=0, slave returns 0 and 1483507502, pulse start: reads at address 0 then 1; done at cycle 3 with pass=1, timeout=0, ts_value=1483507502.
- EXPECTED_TS=1483507503, same slave: done with pass=0, id_value=0, ts_value=1483507502.
- waitrequest held 1 for 3 cycles on each read: read and address stay stable while stalled; done at cycle 9 with pass=1.
- waitrequest stuck at 1, TIMEOUT_CYCLES=4: read drops after 4 stalled cycles; done with timeout=1, pass=0, id_value=0.
- READ_LATENCY=2, with the slave model returning data 2 cycles after acceptance: correct capture and pass=1; start pulsed again while busy is ignored, giving exactly one done.
- reset_n asserted during RD_TS: all outputs return to 0 asynchronously; after release, a new start completes normally with pass=1.
